// File: rtl/dm_cache_ctrl.sv
// dm_cache_ctrl: direct-mapped, write-back, write-allocate data cache controller
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   Addr, DataIn, Rd, Wr           request from the memory-access stage
//   DataOut, Done, Stall           load data, completion, pipeline hold
//   CacheHit, err                  first-lookup hit flag, illegal-condition pulse
//   mem_addr/wdata/req/we          registered backing-memory request (word wide)
//   mem_rdata, mem_done            backing-memory response
module dm_cache_ctrl #(
    parameter int INDEX_BITS = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] Addr,
    input  logic [15:0] DataIn,
    input  logic        Rd,
    input  logic        Wr,
    output logic [15:0] DataOut,
    output logic        Done,
    output logic        Stall,
    output logic        CacheHit,
    output logic        err,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_req,
    output logic        mem_we,
    input  logic [15:0] mem_rdata,
    input  logic        mem_done
);
    localparam int TW    = 13 - INDEX_BITS;
    localparam int LINES = 1 << INDEX_BITS;

    typedef enum logic [2:0] {IDLE, LOOKUP, WB, FILL, RELOOK} state_t;

    state_t                  state, state_n;
    logic [1:0]              cnt, cnt_n;
    logic [15:1]             req_addr;
    logic [15:0]             req_data;
    logic                    req_wr;
    logic [LINES-1:0]        valid, dirty;
    logic [TW-1:0]           tag_arr [LINES];
    logic [15:0]             data_arr [LINES][4];
    logic [TW-1:0]           req_tag;
    logic [INDEX_BITS-1:0]   idx;
    logic [1:0]              woff;
    logic                    hit, accept, hit_wr, fill_wr, last;

    assign req_tag = req_addr[15 -: TW];
    assign idx     = req_addr[INDEX_BITS+2:3];
    assign woff    = req_addr[2:1];
    assign hit     = valid[idx] && tag_arr[idx] == req_tag;

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        accept   = state == IDLE && (Rd ^ Wr) && !Addr[0];
        CacheHit = state == LOOKUP && hit;
        Done     = CacheHit || state == RELOOK;
        Stall    = accept || (state != IDLE && !Done);
        DataOut  = (Done && !req_wr) ? data_arr[idx][woff] : '0;
        err      = (state == IDLE && (Rd || Wr) && !accept) || (mem_done && !mem_req);
        hit_wr   = Done && req_wr;
        fill_wr  = state == FILL && mem_done;
        last     = mem_done && cnt == 2'd3;
        case (state)
            IDLE:    state_n = accept ? LOOKUP : IDLE;
            LOOKUP: begin
                state_n = hit ? IDLE : (valid[idx] && dirty[idx]) ? WB : FILL;
                cnt_n   = '0;
            end
            WB: begin
                cnt_n   = mem_done ? cnt + 2'd1 : cnt;
                state_n = last ? FILL : WB;
            end
            FILL: begin
                cnt_n   = mem_done ? cnt + 2'd1 : cnt;
                state_n = last ? RELOOK : FILL;
            end
            default: state_n = IDLE;
        endcase
    end

    // Memory request signals are registered from the next state, so the
    // address only moves on the edge entering a transfer or sampling mem_done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            valid     <= '0;
            dirty     <= '0;
            req_addr  <= '0;
            req_data  <= '0;
            req_wr    <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            mem_req <= state_n == WB || state_n == FILL;
            mem_we  <= state_n == WB;
            if (accept) begin
                req_addr <= Addr[15:1];
                req_data <= DataIn;
                req_wr   <= Wr;
            end
            if (hit_wr)
                dirty[idx] <= 1'b1;
            if (fill_wr && last) begin
                valid[idx] <= 1'b1;
                dirty[idx] <= 1'b0;
            end
            if (state_n == WB || state_n == FILL)
                mem_addr <= {state_n == WB ? tag_arr[idx] : req_tag, idx, cnt_n, 1'b0};
            if (state_n == WB)
                mem_wdata <= data_arr[idx][cnt_n];
        end
    end

    // Tag and data storage carry no reset; validity alone qualifies them.
    always_ff @(posedge clk) begin
        if (hit_wr)
            data_arr[idx][woff] <= req_data;
        if (fill_wr)
            data_arr[idx][cnt] <= mem_rdata;
        if (fill_wr && last)
            tag_arr[idx] <= req_tag;
    end
endmodule

// File: tb/tb_dm_cache_ctrl.sv
// tb_dm_cache_ctrl: directed self-checking bench for dm_cache_ctrl
module tb_dm_cache_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] Addr = '0;
    logic [15:0] DataIn = '0;
    logic        Rd = 1'b0;
    logic        Wr = 1'b0;
    logic [15:0] DataOut;
    logic        Done, Stall, CacheHit, err;
    logic [15:0] mem_addr, mem_wdata;
    logic        mem_req, mem_we;
    logic [15:0] mem_rdata = '0;
    logic        mem_done;
    logic        model_done = 1'b0;
    logic        force_done = 1'b0;
    int          mode = 1;
    int          w = 0;
    int          checks = 0;
    int          errors = 0;
    logic [15:0] wmem [int];
    logic [15:0] log_a [$];
    logic [15:0] log_d [$];
    logic        log_we [$];

    assign mem_done = model_done | force_done;

    dm_cache_ctrl dut (
        .clk(clk), .rst(rst), .Addr(Addr), .DataIn(DataIn), .Rd(Rd), .Wr(Wr),
        .DataOut(DataOut), .Done(Done), .Stall(Stall), .CacheHit(CacheHit), .err(err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_req(mem_req), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .mem_done(mem_done)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] rd_word(input int a);
        if (wmem.exists(a)) return wmem[a];
        if (a >= 8 && a <= 11) return 16'h1111 * 16'(a - 7);
        return 16'(a) ^ 16'hA5A5;
    endfunction

    task automatic serve();
        log_a.push_back(mem_addr);
        log_we.push_back(mem_we);
        log_d.push_back(mem_wdata);
        if (mem_we) wmem[int'(mem_addr[15:1])] = mem_wdata;
        else mem_rdata = rd_word(int'(mem_addr[15:1]));
    endtask

    // Mode 1: 2-cycle latency per word; mode 2: mem_done held high every cycle.
    always @(negedge clk) begin
        if (mode == 2) begin
            model_done = 1'b1;
            mem_rdata = rd_word(int'(mem_addr[15:1]));
            if (mem_req) serve();
        end else if (model_done) begin
            model_done = 1'b0;
            w = 0;
        end else if (mem_req) begin
            w++;
            if (w >= 2) begin
                model_done = 1'b1;
                serve();
            end
        end else
            w = 0;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic access(input logic rd, input logic wr, input logic [15:0] a,
                          input logic [15:0] d, output int lat,
                          output logic [15:0] dout, output logic hf);
        Rd = rd; Wr = wr; Addr = a; DataIn = d;
        @(posedge clk); #1;
        Rd = 0; Wr = 0;
        lat = 1;
        while (!Done && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("done_seen", Done, 1);
        dout = DataOut;
        hf = CacheHit;
        @(posedge clk); #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int lat, base, n, nw;
        logic [15:0] dout;
        logic hf;
        #2 rst = 1'b1;
        #1;
        chk("rst_stall", Stall, 0);
        chk("rst_done", Done, 0);
        chk("rst_memreq", mem_req, 0);
        chk("rst_dataout", DataOut, 0);
        chk("rst_memaddr", mem_addr, 0);
        chk("rst_err", err, 0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        // cold miss, clean fill
        base = log_a.size();
        access(1, 0, 16'h0010, 0, lat, dout, hf);
        chk("fill_data", dout, 16'h1111);
        chk("fill_hit", hf, 0);
        chk("fill_cnt", log_a.size() - base, 4);
        for (int i = 0; i < 4; i++) begin
            chk("fill_addr", log_a[base + i], 16'h0010 + 16'(2 * i));
            chk("fill_we", log_we[base + i], 0);
        end

        // load hit
        base = log_a.size();
        access(1, 0, 16'h0014, 0, lat, dout, hf);
        chk("rdhit_lat", lat, 1);
        chk("rdhit_data", dout, 16'h3333);
        chk("rdhit_hit", hf, 1);
        chk("rdhit_nomem", log_a.size() - base, 0);

        // store hit
        access(0, 1, 16'h0012, 16'hBEEF, lat, dout, hf);
        chk("wrhit_lat", lat, 1);
        chk("wrhit_hit", hf, 1);

        // conflict on dirty line: writeback then fill
        base = log_a.size();
        access(1, 0, 16'h0112, 0, lat, dout, hf);
        chk("wb_total", log_a.size() - base, 8);
        for (int i = 0; i < 4; i++) begin
            chk("wb_addr", log_a[base + i], 16'h0010 + 16'(2 * i));
            chk("wb_we", log_we[base + i], 1);
            chk("rf_addr", log_a[base + 4 + i], 16'h0110 + 16'(2 * i));
            chk("rf_we", log_we[base + 4 + i], 0);
        end
        chk("wb_w0", log_d[base], 16'h1111);
        chk("wb_w1", log_d[base + 1], 16'hBEEF);
        chk("wb_w2", log_d[base + 2], 16'h3333);
        chk("wb_w3", log_d[base + 3], 16'h4444);
        chk("wb_mem", rd_word(9), 16'hBEEF);
        chk("rf_data", dout, 16'hA52C);
        chk("rf_hit", hf, 0);

        // conflict on clean line: fill only
        base = log_a.size();
        access(1, 0, 16'h0214, 0, lat, dout, hf);
        nw = 0;
        for (int i = base; i < log_a.size(); i++) nw += int'(log_we[i]);
        chk("clean_cnt", log_a.size() - base, 4);
        chk("clean_nowb", nw, 0);
        chk("clean_data", dout, 16'hA4AF);

        // misaligned and dual requests
        Rd = 1; Addr = 16'h0011; #1;
        chk("mis_err", err, 1);
        chk("mis_stall", Stall, 0);
        @(posedge clk); #1; Rd = 0; #1;
        chk("mis_err_pulse", err, 0);
        chk("mis_idle", Stall | Done | mem_req, 0);
        Rd = 1; Wr = 1; Addr = 16'h0010; #1;
        chk("dual_err", err, 1);
        chk("dual_stall", Stall, 0);
        @(posedge clk); #1; Rd = 0; Wr = 0; #1;
        chk("dual_err_pulse", err, 0);
        chk("dual_idle", Stall | Done | mem_req, 0);
        @(posedge clk); #1;

        // reset in the middle of a fill
        base = log_a.size();
        Rd = 1; Addr = 16'h0310;
        @(posedge clk); #1; Rd = 0;
        n = 0;
        while (log_a.size() < base + 2 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("midfill_progress", log_a.size() >= base + 2, 1);
        rst = 1'b1; #1;
        chk("midfill_memreq", mem_req, 0);
        chk("midfill_stall", Stall, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        base = log_a.size();
        access(1, 0, 16'h0310, 0, lat, dout, hf);
        chk("refetch_cnt", log_a.size() - base, 4);
        chk("refetch_a0", log_a[base], 16'h0310);
        chk("refetch_a3", log_a[base + 3], 16'h0316);
        chk("refetch_data", dout, 16'hA42D);
        chk("refetch_hit", hf, 0);

        // spurious mem_done while idle
        force_done = 1'b1; #1;
        chk("spur_err", err, 1);
        @(posedge clk); #1; force_done = 1'b0; #1;
        chk("spur_err_pulse", err, 0);
        access(1, 0, 16'h0312, 0, lat, dout, hf);
        chk("spur_keep_lat", lat, 1);
        chk("spur_keep_data", dout, 16'hA42C);

        // zero-latency memory
        mode = 2;
        access(1, 0, 16'h0418, 0, lat, dout, hf);
        chk("zl_lat", lat, 6);
        chk("zl_data", dout, 16'hA7A9);
        chk("zl_hit", hf, 0);
        mode = 1;
        repeat (3) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dm_cache_ctrl.md
Name: dm_cache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate data cache controller between the memory-access stage and a multi-cycle word-wide backing memory.
- Replaces the single-cycle data memory. It presents Stall/Done to the pipeline so the memory-access stage freezes while a miss is serviced.
- Holds tag, valid, dirty and data arrays internally in flops. Lines are 4 words of 16 bits each.

Parameters:
- INDEX_BITS, 5, number of index bits; there are 2^INDEX_BITS lines. Tag width is 13-INDEX_BITS (addr = tag | index | word offset[2:1] | byte[0]).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- Addr  in  16  byte address from the memory-access stage
- DataIn  in  16  store data
- Rd  in  1  load request
- Wr  in  1  store request
- DataOut  out  16  load data, valid only while Done=1
- Done  out  1  request complete this cycle
- Stall  out  1  pipeline must hold Addr/DataIn/Rd/Wr stable
- CacheHit  out  1  Done for a request that hit on its first lookup
- err  out  1  illegal condition (1-cycle pulse)
- mem_addr  out  16  backing-memory word address (bit0=0)
- mem_wdata  out  16  backing-memory write data
- mem_req  out  1  backing-memory request, registered
- mem_we  out  1  1=write, 0=read; qualifies mem_req
- mem_rdata  in  16  read data, valid with mem_done
- mem_done  in  1  completes the request present this cycle

Behaviour:
- Reset (async): all valid and dirty bits cleared, state IDLE, the 2-bit word counter cleared. mem_req, mem_we, Done, CacheHit, err, Stall are 0. DataOut, mem_addr and mem_wdata are 0. Data and tag arrays are not cleared. Reset during WB or FILL abandons the transfer; mem_req falls immediately.
- States: IDLE, LOOKUP, WB, FILL, RELOOK.
- IDLE:
  - Rd^Wr with Addr[0]=0: latch Addr, DataIn and op; go to LOOKUP. Stall=1 this cycle.
  - Rd&Wr both high, or Addr[0]=1 with Rd|Wr: err=1, request dropped, stay IDLE, Stall=0.
- LOOKUP, hit (valid && tag match):
  - Done=1, CacheHit=1, Stall=0.
  - Load: DataOut = stored word.
  - Store: word written and dirty set at the clock edge.
  - Next state IDLE. Hit latency is exactly 1 cycle after the request is presented.
- LOOKUP, miss: Stall=1. Go to WB if the victim is valid and dirty, else go to FILL. The counter resets to 0.
- WB:
  - mem_req=1, mem_we=1, mem_addr={victim tag, index, cnt, 1'b0}, mem_wdata=victim word[cnt].
  - On mem_done, cnt increments. After the 4th done, cnt=0 and the state goes to FILL.
- FILL:
  - mem_req=1, mem_we=0, mem_addr={req tag, index, cnt, 1'b0}.
  - On mem_done, mem_rdata is written into word[cnt] at the edge.
  - After the 4th done: set valid, write tag, clear dirty, go to RELOOK.
- RELOOK: behaves as a LOOKUP hit (Done=1, CacheHit=0, store merges and sets dirty), then IDLE.
- mem_req timing:
  - mem_req may stay high back-to-back between consecutive words. mem_addr changes only on the edge that samples mem_done.
  - mem_req falls on the edge after the last done of FILL.
  - mem_done with mem_req=0 raises err=1 and is otherwise ignored.
- Stall=1 in every non-IDLE state, except in the cycle Done=1.
- Inputs are ignored outside IDLE.
- Word 0 is at byte offset 0.

Test Plan:
- Reset, then Rd Addr=0x0010, memory returns 0x1111..0x4444 at 2-cycle latency:
  - 4 reads at 0x0010, 0x0012, 0x0014, 0x0016.
  - No WB.
  - Done with DataOut=0x1111, CacheHit=0.
  - Then Rd 0x0014 gives Done the next cycle, DataOut=0x3333, CacheHit=1, no mem_req.
- Wr 0x0012 with 0xBEEF on a resident line:
  - 1-cycle Done with CacheHit=1.
  - Then Rd 0x0112 (same index, different tag) issues 4 writes to 0x0010..0x0016, where 0x0012 carries 0xBEEF, followed by 4 reads at 0x0110..0x0116.
- Rd on a clean valid line conflicting with index 2 gives FILL only; the mem_we=1 count is 0.
- Rd with Addr=0x0011 gives err=1 for one cycle, Stall=0, no state change. The same result holds for Rd=Wr=1.
- Assert rst after the 2nd mem_done of a FILL:
  - mem_req=0 and state IDLE immediately.
  - A repeat of the same Rd misses again and refetches all 4 words.
- mem_done=1 while IDLE gives err=1 and the arrays are unchanged.
- mem_done held high every cycle (0-latency) gives a clean-miss Done exactly 6 cycles after the request is presented.
